// File: rtl/sound_lut_arbiter_if.sv
// Request/response bundle between the sound channels plus table loader and
// the port-A arbiter of the sound lookup-table BRAM.
interface sound_lut_arbiter_if #(
    parameter int NCH = 4,
    parameter int AW  = 11,
    parameter int DW  = 32
);
    logic [NCH-1:0]    rd_req;
    logic [NCH*AW-1:0] rd_addr;
    logic [NCH-1:0]    rd_ack;
    logic [NCH-1:0]    rd_valid;
    logic [DW-1:0]     rd_data;
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_ack;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_ack, rd_valid, rd_data, wr_ack
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_ack, rd_valid, rd_data, wr_ack
    );
endinterface

// File: rtl/sound_lut_arbiter.sv
// Port-A arbiter for the 2048x32 sound LUT: bounded-priority loader writes,
// round-robin channel reads, registered BRAM controls, 2-cycle read valid.
module sound_lut_arbiter #(
    parameter int NCH          = 4,
    parameter int AW           = 11,
    parameter int DW           = 32,
    parameter int MAX_WR_BURST = 4
) (
    input  logic                clka,
    input  logic                rsta,
    sound_lut_arbiter_if.slave  bus,
    output logic                bram_we,
    output logic [AW-1:0]       bram_addr,
    output logic [DW-1:0]       bram_din,
    input  logic [DW-1:0]       bram_douta
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(MAX_WR_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_WR_BURST);

    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  wr_burst_cnt_q, wr_burst_cnt_d;
    logic [NCH-1:0] vld_s1_q, rd_valid_q;
    logic           bram_we_q, bram_we_d;
    logic [AW-1:0]  bram_addr_q, bram_addr_d;
    logic [DW-1:0]  bram_din_q, bram_din_d;

    logic           wr_grant;
    logic           rd_any;
    logic [NCH-1:0] rd_grant;
    logic [PW-1:0]  rd_sel;
    logic [PW:0]    cand;
    logic [AW-1:0]  rd_sel_addr;
    logic           burst_block;

    // Once the loader has used its burst, a pending read gets one slot.
    assign burst_block = (wr_burst_cnt_q == BURST_MAX) && (|bus.rd_req);

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        wr_grant = 1'b0;
        rd_grant = '0;
        rd_any   = 1'b0;
        rd_sel   = '0;
        cand     = '0;
        if (!rsta) begin
            if (bus.wr_req && !burst_block) begin
                wr_grant = 1'b1;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
                    if (cand >= (PW+1)'(NCH)) cand = cand - (PW+1)'(NCH);
                    if (!rd_any && bus.rd_req[cand[PW-1:0]]) begin
                        rd_any = 1'b1;
                        rd_sel = cand[PW-1:0];
                    end
                end
                if (rd_any) rd_grant[rd_sel] = 1'b1;
            end
        end
    end

    assign rd_sel_addr = bus.rd_addr[rd_sel*AW +: AW];

    always_comb begin
        bram_we_d      = 1'b0;
        bram_addr_d    = bram_addr_q;
        bram_din_d     = bram_din_q;
        rr_ptr_d       = rr_ptr_q;
        wr_burst_cnt_d = '0;
        if (wr_grant) begin
            bram_we_d      = 1'b1;
            bram_addr_d    = bus.wr_addr;
            bram_din_d     = bus.wr_data;
            wr_burst_cnt_d = (wr_burst_cnt_q == BURST_MAX) ? wr_burst_cnt_q
                                                           : wr_burst_cnt_q + 1'b1;
        end else if (rd_any) begin
            bram_addr_d = rd_sel_addr;
            rr_ptr_d    = (rd_sel == PW'(NCH - 1)) ? '0 : rd_sel + 1'b1;
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            rr_ptr_q       <= '0;
            wr_burst_cnt_q <= '0;
            vld_s1_q       <= '0;
            rd_valid_q     <= '0;
            bram_we_q      <= 1'b0;
            bram_addr_q    <= '0;
            bram_din_q     <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            rr_ptr_q       <= rr_ptr_d;
            wr_burst_cnt_q <= wr_burst_cnt_d;
            vld_s1_q       <= rd_grant;
            rd_valid_q     <= vld_s1_q;
            bram_we_q      <= bram_we_d;
            bram_addr_q    <= bram_addr_d;
            bram_din_q     <= bram_din_d;
        end
    end

    assign bus.rd_ack   = rd_grant;
    assign bus.wr_ack   = wr_grant;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = bram_douta;
    assign bram_we      = bram_we_q;
    assign bram_addr    = bram_addr_q;
    assign bram_din     = bram_din_q;
endmodule

// File: tb/tb_sound_lut_arbiter.sv
// Directed bench for sound_lut_arbiter: a BRAM model, acks checked per cycle,
// read results checked by a scoreboard monitor against hand-computed data.
module tb_sound_lut_arbiter;
    localparam int NCH = 4;
    localparam int AW  = 11;
    localparam int DW  = 32;

    typedef struct {
        logic [NCH-1:0] ch;
        logic [DW-1:0]  data;
    } exp_t;

    logic          clka = 1'b0;
    logic          rsta = 1'b1;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_douta;
    logic [DW-1:0] mem [0:2047];

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    sound_lut_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

    sound_lut_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MAX_WR_BURST(4)) dut (
        .clka       (clka),
        .rsta       (rsta),
        .bus        (bus),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_douta (bram_douta)
    );

    always #5 clka = ~clka;

    // Single-port BRAM, 1-cycle registered read, read-first.
    always @(posedge clka) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_douta <= mem[bram_addr];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest expected read.
    always @(negedge clka) begin
        if (bus.rd_valid !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_rd_valid", 64'(bus.rd_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_rd_valid", 64'(bus.rd_valid), 64'(mon_e.ch));
                check("sb_rd_data", 64'(bus.rd_data), 64'(mon_e.data));
            end
        end
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic ack_at_neg(input string nm, input logic [NCH-1:0] rd_exp,
                              input logic wr_exp, input logic [DW-1:0] d_exp,
                              input bit push);
        @(negedge clka);
        check({nm, "_rd_ack"}, 64'(bus.rd_ack), 64'(rd_exp));
        check({nm, "_wr_ack"}, 64'(bus.wr_ack), 64'(wr_exp));
        if (push && rd_exp != '0) sb.push_back('{rd_exp, d_exp});
    endtask

    task automatic set_rd(input int ch, input logic [AW-1:0] a);
        bus.rd_addr[ch*AW +: AW] = a;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[11'h05A] = 32'hDEADBEEF;
        mem[11'h010] = 32'hA0A00010;
        mem[11'h011] = 32'hA0A00011;
        mem[11'h012] = 32'hA0A00012;
        mem[11'h013] = 32'hA0A00013;
        mem[11'h100] = 32'hBAD0BAD0;
        mem[11'h300] = 32'h33333333;
        mem[11'h7FF] = 32'h7FF7FF00;

        bus.rd_req  = '0;
        bus.rd_addr = '0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset: requests present while rsta is high must not be granted.
        repeat (2) step();
        bus.rd_req = '1;
        bus.wr_req = 1'b1;
        @(negedge clka);
        check("rst_rd_ack", 64'(bus.rd_ack), 64'd0);
        check("rst_wr_ack", 64'(bus.wr_ack), 64'd0);
        check("rst_bram_we", 64'(bram_we), 64'd0);
        check("rst_bram_addr", 64'(bram_addr), 64'd0);
        check("rst_bram_din", 64'(bram_din), 64'd0);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        step();
        bus.rd_req = '0;
        bus.wr_req = 1'b0;
        rsta       = 1'b0;

        // Single read of 0x05A on channel 1, exact 2-cycle latency.
        set_rd(1, 11'h05A);
        bus.rd_req = 4'b0010;
        ack_at_neg("t1", 4'b0010, 1'b0, 32'hDEADBEEF, 1'b1);
        step();
        bus.rd_req = '0;
        @(negedge clka);
        check("t1_valid_k1", 64'(bus.rd_valid), 64'd0);
        check("t1_bram_addr", 64'(bram_addr), 64'h05A);
        check("t1_bram_we", 64'(bram_we), 64'd0);
        step();
        @(negedge clka);
        check("t1_valid_k2", 64'(bus.rd_valid), 64'b0010);
        step();
        repeat (2) step();

        // Reset one cycle after a read ack: pointer is 2, so channel 1 wins after wrap.
        bus.rd_req = 4'b0010;
        ack_at_neg("t5", 4'b0010, 1'b0, 32'h0, 1'b0);
        step();
        bus.rd_req = '0;
        rsta       = 1'b1;
        @(negedge clka);
        check("t5_bram_addr", 64'(bram_addr), 64'd0);
        check("t5_bram_we", 64'(bram_we), 64'd0);
        check("t5_rd_valid", 64'(bus.rd_valid), 64'd0);
        step();
        @(negedge clka);
        check("t5_rd_valid_late", 64'(bus.rd_valid), 64'd0);
        step();
        rsta = 1'b0;

        // All four channels continuously: round robin from channel 0.
        for (int c = 0; c < NCH; c++) set_rd(c, 11'h010 + 11'(c));
        bus.rd_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            ack_at_neg("t2", 4'b0001 << (i % NCH), 1'b0, 32'hA0A00010 + 32'(i % NCH), 1'b1);
            step();
        end
        bus.rd_req = '0;

        // Write then read of 0x100: write wins, read next cycle sees new data.
        bus.wr_req  = 1'b1;
        bus.wr_addr = 11'h100;
        bus.wr_data = 32'h12345678;
        set_rd(0, 11'h100);
        bus.rd_req  = 4'b0001;
        ack_at_neg("t3_wr", 4'b0000, 1'b1, 32'h0, 1'b0);
        step();
        bus.wr_req = 1'b0;
        ack_at_neg("t3_rd", 4'b0001, 1'b0, 32'h12345678, 1'b1);
        check("t3_bram_we", 64'(bram_we), 64'd1);
        check("t3_bram_addr", 64'(bram_addr), 64'h100);
        check("t3_bram_din", 64'(bram_din), 64'h12345678);
        step();
        bus.rd_req = '0;
        repeat (3) step();

        // Write burst limit: 4 writes, forced read on channel 2, writes resume.
        set_rd(2, 11'h300);
        bus.rd_req = 4'b0100;
        bus.wr_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.wr_addr = 11'h200 + 11'(c);
            bus.wr_data = 32'hC0DE0000 + 32'(c);
            ack_at_neg("t4", (c == 4) ? 4'b0100 : 4'b0000, (c != 4), 32'h33333333, 1'b1);
            if (c > 0) check("t4_bram_we", 64'(bram_we), 64'(c - 1 != 4));
            step();
            if (c == 4) bus.rd_req = '0;
        end
        bus.wr_req = 1'b0;
        @(negedge clka);
        check("t4_last_we", 64'(bram_we), 64'd1);
        check("t4_last_addr", 64'(bram_addr), 64'h209);
        check("t4_last_din", 64'(bram_din), 64'hC0DE0009);
        step();
        repeat (3) step();

        // Read of 0x7FF then idle: address holds, nothing granted, no extra valids.
        set_rd(3, 11'h7FF);
        bus.rd_req = 4'b1000;
        ack_at_neg("t6", 4'b1000, 1'b0, 32'h7FF7FF00, 1'b1);
        step();
        bus.rd_req = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clka);
            check("t6_rd_ack", 64'(bus.rd_ack), 64'd0);
            check("t6_wr_ack", 64'(bus.wr_ack), 64'd0);
            check("t6_bram_we", 64'(bram_we), 64'd0);
            check("t6_bram_addr", 64'(bram_addr), 64'h7FF);
            if (c >= 3) check("t6_rd_valid", 64'(bus.rd_valid), 64'd0);
            step();
        end

        repeat (3) step();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sound_lut_arbiter.md
Name: sound_lut_arbiter

Overview:
- Shares port A of the 2048x32 sound lookup-table BRAM among NCH sound-channel read requesters and one table-loader write requester.
- Sits between the channel waveform generators / loader and the BRAM instance; drives the BRAM's clka-domain port A controls and returns read data with per-channel valid strobes.
- Writes have priority, bounded by a burst limit; reads are arbitrated round-robin.

Parameters:
- NCH, 4, number of read requesters (sound channels).
- AW, 11, BRAM address width.
- DW, 32, BRAM data width.
- MAX_WR_BURST, 4, maximum consecutive write grants while any read is pending.

Ports:
- clka  in  1  clock.
- rsta  in  1  reset, asynchronous, active-high.
- rd_req  in  NCH  per-channel read request (level, held until acked).
- rd_addr  in  NCH*AW  packed read addresses; channel i at bits [i*AW +: AW].
- rd_ack  out  NCH  one-hot combinational grant; request is consumed in the cycle ack is high.
- rd_valid  out  NCH  one-hot, high when rd_data holds channel i's result.
- rd_data  out  DW  read data (bram_douta passthrough).
- wr_req  in  1  loader write request (level, held until acked).
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- wr_ack  out  1  combinational write grant.
- bram_we  out  1  to BRAM wea (registered).
- bram_addr  out  AW  to BRAM addra (registered).
- bram_din  out  DW  to BRAM dina (registered).
- bram_douta  in  DW  from BRAM douta (1-cycle registered read).

Behaviour:
- Reset (async, rsta=1): bram_we=0, bram_addr=0, bram_din=0, rd_valid=0, rr_ptr=0, wr_burst_cnt=0, valid pipeline cleared. rd_ack/wr_ack are combinational and go to 0 whenever rsta=1.
- Grant decision (combinational, each cycle):
  - If wr_req and not (wr_burst_cnt==MAX_WR_BURST and |rd_req): wr_ack=1 and rd_ack=0.
  - Else, if |rd_req: grant the first i with rd_req[i] searching rr_ptr, rr_ptr+1, ... mod NCH.
  - At most one ack is high per cycle.
- Issue (posedge ending the grant cycle):
  - Write grant: bram_we<=1, bram_addr<=wr_addr, bram_din<=wr_data.
  - Read grant i: bram_we<=0, bram_addr<=rd_addr[i], rr_ptr<=(i+1) mod NCH.
  - No grant: bram_we<=0; bram_addr and bram_din hold.
- wr_burst_cnt:
  - Increments (saturating at MAX_WR_BURST) on each write grant.
  - Clears on any read grant or any cycle with wr_req=0.
  - After the limit is reached, the forced read clears it, so writes then resume.
- Read latency: ack in cycle k; BRAM samples the address at posedge k+1; rd_valid[i]=1 and rd_data valid in cycle k+2 only. The valid pipeline is a 2-stage one-hot shift register.
- Throughput: one grant per cycle. Back-to-back reads yield back-to-back rd_valid pulses in grant order.
- Ordering: a read granted in any cycle after a write grant to the same address returns the new data. Same-cycle write/read conflict is impossible because writes win.
- rr_ptr changes only on read grants. No requester waits more than NCH-1 read grants once it is the only non-served requester; writes delay reads by at most MAX_WR_BURST cycles.
- Reset mid-operation: in-flight reads are dropped with no rd_valid; requesters re-request after reset.
- rd_addr of non-granted channels is ignored. rd_req dropped before ack is legal (request withdrawn).

Test Plan:
- Reset then single read: rd_req=4'b0010, rd_addr[1]=11'h05A, BRAM preloaded 32'hDEADBEEF at 0x05A -> rd_ack=4'b0010 in cycle k, rd_valid=4'b0010 with rd_data=32'hDEADBEEF in cycle k+2, no other valid pulses.
- All four channels requesting continuously from rr_ptr=0 -> acks 0,1,2,3,0,1,… one per cycle; rd_valid follows the same order 2 cycles later.
- Write then read same address: wr_req at 0x100 with 32'h12345678, rd_req[0] at 0x100 asserted simultaneously -> write acked first, read acked next cycle, rd_data=32'h12345678.
- Write burst limit: wr_req held high for 10 cycles with rd_req[2] high -> 4 wr_acks, then 1 rd_ack[2], then writes resume; bram_we low exactly in the read-issue cycle.
- Reset mid-flight: assert rsta one cycle after rd_ack -> no rd_valid ever appears; all outputs return to reset values; first grant after reset starts search at channel 0.
- Idle hold: no requests for 5 cycles after a read of 0x7FF -> bram_we=0, bram_addr stays 0x7FF, no acks or valids.
